// File: rtl/lsq_pkg.sv
// Shared types for the memory issue queue: the uop record, the head entry
// state, and the robid age compare that memblock also uses for its flush.
package lsq_pkg;

  localparam int PREG_W = 7;

  typedef struct packed {
    logic [31:0]       instr;
    logic [63:0]       pc;
    logic [7:0]        robid;
    logic [PREG_W-1:0] prd;
    logic [PREG_W-1:0] prs1;
    logic [PREG_W-1:0] prs2;
    logic [31:0]       imm;
    logic              is_load;
    logic              is_store;
    logic              is_unsigned;
    logic [3:0]        ls_size;
  } lsq_uop_t;

  typedef enum logic {
    ST_WAIT   = 1'b0,
    ST_ISSUED = 1'b1
  } lsq_state_e;

  // True when robid e is younger than the redirecting robid f. The top bit is
  // a wrap flag, so a flipped flag inverts the ordering of the low bits.
  function automatic logic robid_younger(input logic [7:0] e, input logic [7:0] f);
    return (e[7] ^ f[7]) ^ (f[6:0] < e[6:0]);
  endfunction

endpackage

// File: rtl/lsq_wakeup_match.sv
// Compares one uop's two source tags against both writeback ports.
// Tag 0 is the hardwired zero register: always a hit, value 0.
module lsq_wakeup_match
  import lsq_pkg::*;
(
  input  logic [PREG_W-1:0] i_prs1,
  input  logic [PREG_W-1:0] i_prs2,
  input  logic              i_wb0_valid,
  input  logic [PREG_W-1:0] i_wb0_prd,
  input  logic [63:0]       i_wb0_data,
  input  logic              i_wb1_valid,
  input  logic [PREG_W-1:0] i_wb1_prd,
  input  logic [63:0]       i_wb1_data,
  output logic              o_hit1,
  output logic [63:0]       o_data1,
  output logic              o_hit2,
  output logic [63:0]       o_data2
);

  logic w_s1_wb0, w_s1_wb1, w_s2_wb0, w_s2_wb1;
  logic w_s1_zero, w_s2_zero;

  assign w_s1_zero = (i_prs1 == '0);
  assign w_s2_zero = (i_prs2 == '0);
  assign w_s1_wb0  = i_wb0_valid & (i_wb0_prd == i_prs1);
  assign w_s1_wb1  = i_wb1_valid & (i_wb1_prd == i_prs1);
  assign w_s2_wb0  = i_wb0_valid & (i_wb0_prd == i_prs2);
  assign w_s2_wb1  = i_wb1_valid & (i_wb1_prd == i_prs2);

  assign o_hit1  = w_s1_zero | w_s1_wb0 | w_s1_wb1;
  assign o_hit2  = w_s2_zero | w_s2_wb0 | w_s2_wb1;
  assign o_data1 = w_s1_zero ? 64'd0 : (w_s1_wb0 ? i_wb0_data : i_wb1_data);
  assign o_data2 = w_s2_zero ? 64'd0 : (w_s2_wb0 ? i_wb0_data : i_wb1_data);

endmodule

// File: rtl/lsq_issue_queue.sv
// In-order load/store issue queue in front of memblock. The head uop is held
// stable from issue until mem_complete. Optional macro LSQ_ENQ_BYPASS_EN lets
// an operand-ready uop entering an empty queue present in the same cycle.
module lsq_issue_queue
  import lsq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  lsq_uop_t          enq_uop,
  input  logic              enq_src1_rdy,
  input  logic              enq_src2_rdy,
  input  logic [63:0]       enq_src1,
  input  logic [63:0]       enq_src2,
  input  logic              wb0_valid,
  input  logic              wb1_valid,
  input  logic [PREG_W-1:0] wb0_prd,
  input  logic [PREG_W-1:0] wb1_prd,
  input  logic [63:0]       wb0_data,
  input  logic [63:0]       wb1_data,
  output logic              iss_valid,
  input  logic              iss_ready,
  output lsq_uop_t          iss_uop,
  output logic [63:0]       iss_src1,
  output logic [63:0]       iss_src2,
  input  logic              mem_complete,
  input  logic              flush_valid,
  input  logic [7:0]        flush_robid,
  output logic [PTR_W:0]    lsq_count
);

  localparam logic [PTR_W:0] PTR_ONE  = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0] FULL_XOR = {1'b1, {PTR_W{1'b0}}};

  logic [PTR_W:0] r_head, r_tail;
  logic           r_valid  [DEPTH];
  logic           r_s1_rdy [DEPTH];
  logic           r_s2_rdy [DEPTH];
  lsq_state_e     r_state  [DEPTH];
  lsq_uop_t       r_uop    [DEPTH];
  logic [63:0]    r_src1   [DEPTH];
  logic [63:0]    r_src2   [DEPTH];

  logic           w_hit1 [DEPTH];
  logic           w_hit2 [DEPTH];
  logic [63:0]    w_data1 [DEPTH];
  logic [63:0]    w_data2 [DEPTH];
  logic           w_kill [DEPTH];
  logic           w_deq_ent [DEPTH];

  logic [PTR_W-1:0] w_head_idx, w_enq_idx;
  logic [PTR_W:0]   w_head_after, w_tail_after, w_tail_next, w_surv;
  logic             w_full, w_head_ready, w_head_fire, w_deq;
  logic             w_enq_fire, w_enq_keep, w_bypass;
  logic             w_enq_hit1, w_enq_hit2, w_enq_s1_rdy, w_enq_s2_rdy;
  logic [63:0]      w_enq_data1, w_enq_data2, w_enq_s1_val, w_enq_s2_val;

  // One wakeup comparator per stored entry.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    lsq_wakeup_match u_match (
      .i_prs1(r_uop[gi].prs1), .i_prs2(r_uop[gi].prs2),
      .i_wb0_valid(wb0_valid), .i_wb0_prd(wb0_prd), .i_wb0_data(wb0_data),
      .i_wb1_valid(wb1_valid), .i_wb1_prd(wb1_prd), .i_wb1_data(wb1_data),
      .o_hit1(w_hit1[gi]), .o_data1(w_data1[gi]),
      .o_hit2(w_hit2[gi]), .o_data2(w_data2[gi])
    );
  end

  // The incoming uop also snoops this cycle's writebacks.
  lsq_wakeup_match u_enq_match (
    .i_prs1(enq_uop.prs1), .i_prs2(enq_uop.prs2),
    .i_wb0_valid(wb0_valid), .i_wb0_prd(wb0_prd), .i_wb0_data(wb0_data),
    .i_wb1_valid(wb1_valid), .i_wb1_prd(wb1_prd), .i_wb1_data(wb1_data),
    .o_hit1(w_enq_hit1), .o_data1(w_enq_data1),
    .o_hit2(w_enq_hit2), .o_data2(w_enq_data2)
  );

  assign w_head_idx   = r_head[PTR_W-1:0];
  assign w_full       = ((r_head ^ r_tail) == FULL_XOR);
  assign enq_ready    = ~w_full;
  assign lsq_count    = r_tail - r_head;
  assign w_enq_fire   = enq_valid & ~w_full;
  assign w_enq_keep   = w_enq_fire & ~(flush_valid & robid_younger(enq_uop.robid, flush_robid));
  assign w_enq_s1_rdy = enq_src1_rdy | w_enq_hit1;
  assign w_enq_s2_rdy = enq_src2_rdy | w_enq_hit2;
  assign w_enq_s1_val = (enq_uop.prs1 == '0) ? 64'd0 : (enq_src1_rdy ? enq_src1 : w_enq_data1);
  assign w_enq_s2_val = (enq_uop.prs2 == '0) ? 64'd0 : (enq_src2_rdy ? enq_src2 : w_enq_data2);
  assign w_head_ready = r_valid[w_head_idx] & r_s1_rdy[w_head_idx] &
                        (r_s2_rdy[w_head_idx] | r_uop[w_head_idx].is_load);
  assign w_head_fire  = w_head_ready & iss_ready & (r_state[w_head_idx] == ST_WAIT);
  assign w_deq        = mem_complete & r_valid[w_head_idx] & (r_state[w_head_idx] == ST_ISSUED);
  assign w_head_after = r_head + (w_deq ? PTR_ONE : '0);

`ifdef LSQ_ENQ_BYPASS_EN
  assign w_bypass = (r_head == r_tail) & w_enq_keep & w_enq_s1_rdy &
                    (w_enq_s2_rdy | enq_uop.is_load);
`else
  assign w_bypass = 1'b0;
`endif

  // Dequeue first, then flush the remaining entries; survivors stay a prefix from head.
  always_comb begin
    w_surv = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_deq_ent[i] = w_deq & (w_head_idx == i[PTR_W-1:0]);
      w_kill[i]    = r_valid[i] & flush_valid & robid_younger(r_uop[i].robid, flush_robid);
      w_surv       = w_surv + ((r_valid[i] & ~w_kill[i] & ~w_deq_ent[i]) ? PTR_ONE : '0);
    end
    w_tail_after = flush_valid ? (w_head_after + w_surv) : r_tail;
    w_enq_idx    = w_tail_after[PTR_W-1:0];
    w_tail_next  = w_tail_after + (w_enq_keep ? PTR_ONE : '0);
  end

  // Present the head entry, or the incoming uop when bypassing into an empty queue.
  always_comb begin
    iss_valid = w_head_ready;
    iss_uop   = '0;
    iss_src1  = '0;
    iss_src2  = '0;
    if (w_bypass) begin
      iss_valid = 1'b1;
      iss_uop   = enq_uop;
      iss_src1  = w_enq_s1_val;
      iss_src2  = w_enq_s2_val;
    end else if (w_head_ready) begin
      iss_uop  = r_uop[w_head_idx];
      iss_src1 = r_src1[w_head_idx];
      iss_src2 = r_src2[w_head_idx];
    end
  end

  // Pointer and entry state update: wakeup, issue, dequeue/flush, then enqueue write.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_head <= '0;
      r_tail <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i]  <= 1'b0;
        r_s1_rdy[i] <= 1'b0;
        r_s2_rdy[i] <= 1'b0;
        r_state[i]  <= ST_WAIT;
        r_uop[i]    <= '0;
        r_src1[i]   <= '0;
        r_src2[i]   <= '0;
      end
    end else begin
      r_head <= w_head_after;
      r_tail <= w_tail_next;
      for (int i = 0; i < DEPTH; i++) begin
        if (r_valid[i] & ~r_s1_rdy[i] & w_hit1[i]) begin
          r_s1_rdy[i] <= 1'b1;
          r_src1[i]   <= w_data1[i];
        end
        if (r_valid[i] & ~r_s2_rdy[i] & w_hit2[i]) begin
          r_s2_rdy[i] <= 1'b1;
          r_src2[i]   <= w_data2[i];
        end
        if (w_head_fire & (w_head_idx == i[PTR_W-1:0]))
          r_state[i] <= ST_ISSUED;
        if (w_kill[i] | w_deq_ent[i])
          r_valid[i] <= 1'b0;
        if (w_enq_keep & (w_enq_idx == i[PTR_W-1:0])) begin
          r_valid[i]  <= 1'b1;
          r_uop[i]    <= enq_uop;
          r_s1_rdy[i] <= w_enq_s1_rdy;
          r_s2_rdy[i] <= w_enq_s2_rdy;
          r_src1[i]   <= w_enq_s1_val;
          r_src2[i]   <= w_enq_s2_val;
          r_state[i]  <= (w_bypass & iss_ready) ? ST_ISSUED : ST_WAIT;
        end
      end
    end
  end

endmodule

// File: doc/lsq_issue_queue.md
Name: lsq_issue_queue

Overview:
- In-order memory issue queue sitting directly upstream of memblock.
- Buffers dispatched load/store uops, captures source operands from writeback broadcasts, and presents the oldest uop to memblock.
- Holds the presented uop stable until memblock reports completion, because memblock consumes src/imm/size combinationally for the whole operation.
- Removes squashed uops on redirect flush.

Parameters:
- DEPTH, 8, number of entries; power of two, ≥2.
- PTR_W, $clog2(DEPTH), pointer width; an extra wrap bit is added internally.

Ports:
- clock  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- enq_valid  in  1  dispatch offers a uop
- enq_ready  out  1  space available (not full)
- enq_uop  in  lsq_uop_t  instr, pc, robid[7:0], prd, prs1, prs2, imm, is_load, is_store, is_unsigned, ls_size[3:0]
- enq_src1_rdy  in  1  src1 value already available
- enq_src2_rdy  in  1  src2 value already available
- enq_src1  in  64  src1 value (valid if rdy)
- enq_src2  in  64  src2 value (valid if rdy)
- wb0_valid, wb1_valid  in  1 each  writeback broadcast valid
- wb0_prd, wb1_prd  in  PREG  writeback destination
- wb0_data, wb1_data  in  64  writeback value
- iss_valid  out  1  drives memblock instr_valid
- iss_ready  in  1  memblock instr_ready
- iss_uop  out  lsq_uop_t  head uop fields
- iss_src1, iss_src2  out  64  head operand values
- mem_complete  in  1  memblock_out_instr_valid
- flush_valid  in  1  redirect
- flush_robid  in  8  redirecting robid
- lsq_count  out  PTR_W+1  occupancy

Behaviour:
- Reset: head=tail=0, all entry valid and ready bits 0; iss_valid=0, enq_ready=1, lsq_count=0, iss_uop/iss_src* = 0.
- Enqueue:
  - Fire = enq_valid & enq_ready; the entry is written at tail next edge.
  - full = (head^tail) == {1'b1, PTR_W'b0}; enq_ready = ~full.
- Wakeup:
  - Each cycle, every valid entry with srcN not ready and prsN==wbK_prd & wbK_valid captures wbK_data and sets the ready bit.
  - The enqueuing uop is also compared against same-cycle wb ports. Matches capture the data even though enq_srcN_rdy=0.
  - prs==0 is treated as ready, with value 0.
- Head state per entry: WAIT -> ISSUED -> dequeue.
  - iss_valid = head valid & src1_rdy & (src2_rdy | is_load).
  - WAIT->ISSUED when iss_valid & iss_ready.
  - While ISSUED, iss_valid and all iss_* fields are held constant, regardless of iss_ready.
  - Dequeue (head++) on mem_complete while the head is ISSUED; the next entry may present on the following cycle (1-cycle bubble).
- Younger test: young(e) = (e[7]^flush_robid[7]) ^ (flush_robid[6:0] < e[6:0]).
  - Flush kills every valid entry with young(robid)=1, including the issued head.
  - Survivors form a contiguous prefix from head; tail is set to head+survivors.
  - An enqueue in the flush cycle is dropped if it is young.
  - A killed issued head drops iss_valid next cycle; memblock squashes itself.
- Simultaneous events:
  - Enqueue and dequeue in the same cycle while full: enq_ready is still 0; no bypass of the full flag.
  - mem_complete and flush in the same cycle: dequeue is applied first, then flush on the remaining entries.
  - mem_complete while not ISSUED: ignored.
- Wrap: pointers are PTR_W+1 bits and wrap modulo 2*DEPTH.
- Reset mid-operation clears everything immediately; no completion is awaited.

Optional Feature:
- Macro: LSQ_ENQ_BYPASS_EN.
- Defined: when the queue is empty, enq fires, and the uop is operand-ready (after wb match), iss_valid/iss_uop/iss_src* are driven combinationally from enq in that same cycle. iss_ready that cycle moves the new entry directly to ISSUED.
- Undefined: minimum enqueue-to-iss_valid latency is 1 cycle.

Decomposition:
- Package lsq_pkg holds:
  - lsq_uop_t packed struct
  - entry state enum (WAIT, ISSUED)
  - the robid_younger function, shared with memblock's flush compare
- Sub-module lsq_wakeup_match: compares one entry's prs1/prs2 against both wb ports and returns hit/data. It is instantiated per entry and once for the enq path.

Test Plan:
- Reset, enqueue load (robid 5, src1_rdy=1, imm 0x10), iss_ready=1 → iss_valid on cycle+1; held 4 cycles until mem_complete; count 1→0.
- Enqueue store with src2 not ready (prs2=12); wb1 prd=12 data 0xDEAD two cycles later → iss_valid the cycle after capture, iss_src2=0xDEAD.
- Fill 8 entries → enq_ready=0; single completion → enq_ready=1 next cycle; tail wraps to 0 with wrap bit toggled.
- Entries robid 0x7E, 0x7F, 0x80, 0x81; flush_robid 0x7F → 0x80 and 0x81 killed, count 2, tail = head+2.
- Head ISSUED robid 3, flush_robid 2 → iss_valid=0 next cycle, queue empty; a mem_complete afterwards is ignored.
- With LSQ_ENQ_BYPASS_EN: empty queue, enq operand-ready uop → iss_valid in the same cycle; without the macro → iss_valid one cycle later.
